// File: rtl/lexpander_if.sv
// lexpander_if: valid/ready stream bundle around the logarithmic expander.
//
// Ports (signals):
//   i_valid  1   upstream has a companded code on i_data
//   o_ready  1   expander can accept a code this cycle
//   i_data   8   companded code {sign, exp[2:0], mant[3:0]}
//   o_valid  1   o_data holds an expanded sample
//   i_ready  1   downstream accepts o_data this cycle
//   o_data   OW  signed linear sample
//
// Modports:
//   slave  - the expander's view
//   master - the surrounding environment (producer + consumer)
interface lexpander_if #(
  parameter int OW = 16
);
  logic          i_valid;
  logic          o_ready;
  logic [7:0]    i_data;
  logic          o_valid;
  logic          i_ready;
  logic [OW-1:0] o_data;

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data
  );

  modport master (
    output i_valid,
    output i_data,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data
  );
endinterface

// File: rtl/lexpander.sv
// lexpander: expands 8-bit sign/exponent/mantissa codes to signed linear
// samples. Three-stage valid/ready pipeline (latch, shift, sign) with
// bubble collapsing; one sample per clock when unstalled.
//
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous, active-high; empties the pipeline
//   bus      lexpander_if.slave (i_valid/o_ready/i_data in,
//            o_valid/i_ready/o_data out)
//
// Decode: M = m for e = 0, else {1,m} << (e-1); result = sign ? -M : M.
// Code 0x80 yields 0 naturally, since -0 is 0 in two's complement.
module lexpander #(
  parameter int OW = 16
) (
  input  logic      i_clk,
  input  logic      i_reset,
  lexpander_if.slave bus
);

  // Stage S1: raw code fields
  logic        v1;
  logic        s1;
  logic [2:0]  e1;
  logic [3:0]  m1;

  // Stage S2: sign and 11-bit magnitude
  logic        v2;
  logic        s2;
  logic [10:0] mag2;

  // Stage S3: final signed sample
  logic          v3;
  logic [OW-1:0] d3;

  // Stage load enables; each stage loads when empty or when its content
  // moves on, so empty stages fill even while the tail is stalled.
  logic ld1;
  logic ld2;
  logic ld3;

  logic [10:0]   mant;
  logic [10:0]   mag_next;
  logic [OW-1:0] ext;

  always_comb begin
    ld3 = !v3 || bus.i_ready;
    ld2 = !v2 || ld3;
    ld1 = !v1 || ld2;
  end

  always_comb begin
    mant     = {6'd0, 1'b1, m1};
    mag_next = {7'd0, m1};
    if (e1 != 3'd0) begin
      mag_next = mant << (e1 - 3'd1);
    end
  end

  always_comb begin
    ext = {{(OW-11){1'b0}}, mag2};
  end

  // S1: latch incoming code
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      e1 <= 3'd0;
      m1 <= 4'd0;
    end else if (ld1) begin
      v1 <= bus.i_valid;
      if (bus.i_valid) begin
        s1 <= bus.i_data[7];
        e1 <= bus.i_data[6:4];
        m1 <= bus.i_data[3:0];
      end
    end
  end

  // S2: magnitude shift
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      v2   <= 1'b0;
      s2   <= 1'b0;
      mag2 <= 11'd0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2   <= s1;
        mag2 <= mag_next;
      end
    end
  end

  // S3: sign application and sign extension
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      v3 <= 1'b0;
      d3 <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        d3 <= s2 ? -ext : ext;
      end
    end
  end

  // o_ready depends only on downstream ready and stage occupancy.
  assign bus.o_ready = ld1;
  assign bus.o_valid = v3;
  assign bus.o_data  = d3;

endmodule

// File: tb/tb_lexpander.sv
// tb_lexpander: table-driven and scoreboard-based bench for lexpander.
module tb_lexpander;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lexpander_if #(.OW(OW)) bus();

  lexpander #(.OW(OW)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0]    code;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t q[$];
  vec_t tbl[8];

  int n_vec = 0;
  int n_bad = 0;
  int done  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference decode written as repeated doubling.
  function automatic int expand(input logic [7:0] c);
    int mag;
    int e;
    e   = int'(c[6:4]);
    mag = int'(c[3:0]);
    if (e != 0) begin
      mag = mag + 16;
      for (int i = 1; i < e; i++) mag = mag * 2;
    end
    return c[7] ? -mag : mag;
  endfunction

  // Reference compressor (the lcompressor transfer function on exact points).
  function automatic logic [7:0] compress(input int x);
    int mag;
    int e;
    int m;
    logic s;
    logic [2:0] eb;
    logic [3:0] mb;
    s   = (x < 0);
    mag = s ? -x : x;
    if (mag < 16) begin
      mb = mag[3:0];
      return {s, 3'd0, mb};
    end
    e = 1;
    while ((mag >> (e - 1)) > 31) e++;
    m  = (mag >> (e - 1)) - 16;
    eb = e[2:0];
    mb = m[3:0];
    return {s, eb, mb};
  endfunction

  function automatic logic [OW-1:0] to_ow(input int x);
    return x[OW-1:0];
  endfunction

  // Drive one code, wait for acceptance, record expectation.
  task automatic drive_code(input logic [7:0] c, input logic [OW-1:0] e);
    int budget;
    budget = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = c;
    forever begin
      @(negedge clk);
      if (bus.o_ready) break;
      budget++;
      if (budget > 200) begin
        n_vec++;
        n_bad++;
        $display("FAIL accept_timeout: code %0h not accepted, want accept within 200 cycles", c);
        bus.i_valid = 1'b0;
        return;
      end
    end
    q.push_back('{code: c, exp: e});
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.i_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Accept 0x25 now and count edges until o_valid rises (acceptance edge = 1).
  task automatic latency_check(input string name);
    int n;
    drive_code(8'h25, 16'd42);
    n = 1;
    while (!bus.o_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, 3);
  endtask

  // Output monitor: pops on transfer out, checks stall stability.
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, bus.o_valid}, 1);
        check("stall_data", {16'd0, bus.o_data}, {16'd0, prev_data});
      end
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spurious_output: got %0h, want no output", bus.o_data);
        end else begin
          vec_t v;
          int x;
          v = q.pop_front();
          check($sformatf("data_%02h", v.code), {16'd0, bus.o_data}, {16'd0, v.exp});
          if (v.code != 8'h80) begin
            x = int'($signed(bus.o_data));
            check($sformatf("roundtrip_%02h", v.code), {24'd0, compress(x)}, {24'd0, v.code});
          end
        end
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_data  = bus.o_data;
    end
  end

  initial begin
    tbl[0] = '{code: 8'h00, exp: 16'h0000};
    tbl[1] = '{code: 8'h0F, exp: 16'h000F};
    tbl[2] = '{code: 8'h10, exp: 16'h0010};
    tbl[3] = '{code: 8'h7F, exp: 16'h07C0};
    tbl[4] = '{code: 8'h8F, exp: 16'hFFF1};
    tbl[5] = '{code: 8'hA5, exp: 16'hFFD6};
    tbl[6] = '{code: 8'hFF, exp: 16'hF840};
    tbl[7] = '{code: 8'h80, exp: 16'h0000};

    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_valid", {31'd0, bus.o_valid}, 0);
    check("rst_o_data", {16'd0, bus.o_data}, 0);
    rst = 1'b0;
    #1;
    check("rst_o_ready", {31'd0, bus.o_ready}, 1);

    // Latency
    latency_check("latency");
    drain();

    // Table of positive/negative codes, back to back
    for (int i = 0; i < 8; i++) drive_code(tbl[i].code, tbl[i].exp);
    drain();

    // Backpressure: stream 0x30..0x3F with a 6-cycle stall
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [7:0] c;
          c = 8'h30 + 8'(i);
          drive_code(c, to_ow((16 + i) * 4));
        end
      end
      begin
        bus.i_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("full_o_ready", {31'd0, bus.o_ready}, 0);
        check("full_occupancy", q.size(), 3);
        bus.i_ready = 1'b1;
        #1;
        check("release_o_ready", {31'd0, bus.o_ready}, 1);
      end
    join
    drain();

    // Bubble pattern with random downstream ready
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] c;
          c = 8'($urandom_range(0, 255));
          drive_code(c, to_ow(expand(c)));
          @(posedge clk);
          #1;
        end
        done = 1;
      end
      begin
        while (done == 0) begin
          @(posedge clk);
          #1;
          bus.i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Async reset with 3 samples in flight
    bus.i_ready = 1'b0;
    drive_code(8'h11, to_ow(expand(8'h11)));
    drive_code(8'h22, to_ow(expand(8'h22)));
    drive_code(8'h33, to_ow(expand(8'h33)));
    check("inflight_o_valid", {31'd0, bus.o_valid}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_o_valid", {31'd0, bus.o_valid}, 0);
    check("async_rst_o_data", {16'd0, bus.o_data}, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_ready = 1'b1;
    latency_check("latency_after_reset");
    drain();

    // Exhaustive sweep
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'(i);
      drive_code(c, to_ow(expand(c)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
